// File: rtl/alarm_trigger.sv
// Alarm trigger: compares running time against the alarm setting at second 0, rings a
// square-wave buzzer, and handles stop, limited snoozes and auto-off.
module alarm_trigger #(
   parameter int TONE_DIV   = 500,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       SEC_TICK,
   input  logic [6:0] HOUR,
   input  logic [6:0] MIN,
   input  logic [6:0] SEC,
   input  logic [6:0] HOUR_A,
   input  logic [6:0] MIN_A,
   input  logic       ALARM_EN,
   input  logic       STOP,
   input  logic       SNZ,
   output logic       BUZZ,
   output logic       ALARM_ACT,
   output logic [1:0] STATE
);

   localparam int SNZ_TICKS = SNOOZE_MIN * 60;
   localparam int TONE_W    = $clog2(TONE_DIV + 1);
   localparam int RING_W    = $clog2(RING_SEC + 1);
   localparam int TMR_W     = $clog2(SNZ_TICKS + 1);
   localparam int CNT_W     = $clog2(MAX_SNOOZE + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RINGING = 2'b01,
      ST_SNOOZE  = 2'b10
   } state_t;

   state_t            state_reg;
   logic              buzz_reg;
   logic              act_reg;
   logic [TONE_W-1:0] tone_cnt_reg;
   logic [RING_W-1:0] ring_cnt_reg;
   logic [TMR_W-1:0]  snz_tmr_reg;
   logic [CNT_W-1:0]  snz_cnt_reg;

   logic stop_d_reg;
   logic snz_d_reg;
   logic stop_en_reg;
   logic snz_en_reg;

   logic time_match;
   logic snz_ok;
   logic ring_last;
   logic tone_wrap;
   logic tmr_last;

   // One-cycle press pulses; a held button produces a single pulse.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         stop_d_reg  <= 1'b0;
         snz_d_reg   <= 1'b0;
         stop_en_reg <= 1'b0;
         snz_en_reg  <= 1'b0;
      end else begin
         stop_d_reg  <= STOP;
         snz_d_reg   <= SNZ;
         stop_en_reg <= STOP & ~stop_d_reg;
         snz_en_reg  <= SNZ & ~snz_d_reg;
      end
   end

   assign time_match = SEC_TICK && (HOUR == HOUR_A) && (MIN == MIN_A) && (SEC == 7'd0);
   assign snz_ok     = snz_en_reg && (snz_cnt_reg < CNT_W'(MAX_SNOOZE));
   assign ring_last  = ring_cnt_reg >= RING_W'(RING_SEC - 1);
   assign tone_wrap  = tone_cnt_reg >= TONE_W'(TONE_DIV - 1);
   assign tmr_last   = snz_tmr_reg <= TMR_W'(1);

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_reg    <= ST_IDLE;
         buzz_reg     <= 1'b0;
         act_reg      <= 1'b0;
         tone_cnt_reg <= '0;
         ring_cnt_reg <= '0;
         snz_tmr_reg  <= '0;
         snz_cnt_reg  <= '0;
      end else if (!ALARM_EN) begin
         state_reg   <= ST_IDLE;
         buzz_reg    <= 1'b0;
         act_reg     <= 1'b0;
         snz_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (time_match) begin
                  state_reg    <= ST_RINGING;
                  act_reg      <= 1'b1;
                  ring_cnt_reg <= '0;
                  tone_cnt_reg <= '0;
                  buzz_reg     <= 1'b0;
               end
            end
            ST_RINGING: begin
               if (stop_en_reg) begin
                  state_reg   <= ST_IDLE;
                  buzz_reg    <= 1'b0;
                  act_reg     <= 1'b0;
                  snz_cnt_reg <= '0;
               end else if (snz_ok) begin
                  state_reg   <= ST_SNOOZE;
                  snz_cnt_reg <= snz_cnt_reg + CNT_W'(1);
                  snz_tmr_reg <= TMR_W'(SNZ_TICKS);
                  buzz_reg    <= 1'b0;
               end else if (SEC_TICK && ring_last) begin
                  state_reg   <= ST_IDLE;
                  buzz_reg    <= 1'b0;
                  act_reg     <= 1'b0;
                  snz_cnt_reg <= '0;
               end else begin
                  if (tone_wrap) begin
                     tone_cnt_reg <= '0;
                     buzz_reg     <= ~buzz_reg;
                  end else begin
                     tone_cnt_reg <= tone_cnt_reg + TONE_W'(1);
                  end
                  if (SEC_TICK) begin
                     ring_cnt_reg <= ring_cnt_reg + RING_W'(1);
                  end
               end
            end
            ST_SNOOZE: begin
               if (stop_en_reg) begin
                  state_reg   <= ST_IDLE;
                  buzz_reg    <= 1'b0;
                  act_reg     <= 1'b0;
                  snz_cnt_reg <= '0;
               end else if (SEC_TICK) begin
                  if (tmr_last) begin
                     // Snooze over: restart a full ring period from a clean tone phase.
                     state_reg    <= ST_RINGING;
                     snz_tmr_reg  <= '0;
                     ring_cnt_reg <= '0;
                     tone_cnt_reg <= '0;
                     buzz_reg     <= 1'b0;
                  end else begin
                     snz_tmr_reg <= snz_tmr_reg - TMR_W'(1);
                  end
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               buzz_reg    <= 1'b0;
               act_reg     <= 1'b0;
               snz_cnt_reg <= '0;
            end
         endcase
      end
   end

   assign STATE     = state_reg;
   assign BUZZ      = buzz_reg;
   assign ALARM_ACT = act_reg;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: a cycle model pushes expected {STATE,BUZZ,ALARM_ACT} per cycle,
// popped and compared after each clock edge, plus directed scenario checks.
module tb_alarm_trigger;

   localparam int TB_TONE   = 4;
   localparam int TB_RING   = 5;
   localparam int TB_SNZMIN = 1;
   localparam int TB_MAXSNZ = 2;

   logic       clk;
   logic       rst_n;
   logic       sec_tick;
   logic [6:0] cur_hour, cur_min, cur_sec;
   logic [6:0] hour_a, min_a;
   logic       alarm_en, stop_btn, snz_btn;
   logic       buzz, alarm_act;
   logic [1:0] state;

   int err_cnt = 0;
   int chk_cnt = 0;
   logic [3:0] exp_q[$];

   // reference model state
   int m_state, m_buzz, m_ring, m_tone, m_timer, m_snz;
   int m_stop_prev, m_snz_prev, m_stop_en, m_snz_en;

   alarm_trigger #(
      .TONE_DIV(TB_TONE), .RING_SEC(TB_RING), .SNOOZE_MIN(TB_SNZMIN), .MAX_SNOOZE(TB_MAXSNZ)
   ) dut (
      .CLK(clk), .RESETN(rst_n), .SEC_TICK(sec_tick),
      .HOUR(cur_hour), .MIN(cur_min), .SEC(cur_sec),
      .HOUR_A(hour_a), .MIN_A(min_a), .ALARM_EN(alarm_en),
      .STOP(stop_btn), .SNZ(snz_btn),
      .BUZZ(buzz), .ALARM_ACT(alarm_act), .STATE(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_buzz = 0; m_ring = 0; m_tone = 0; m_timer = 0; m_snz = 0;
      m_stop_prev = 0; m_snz_prev = 0; m_stop_en = 0; m_snz_en = 0;
   endtask

   task automatic model_idle();
      m_state = 0; m_buzz = 0; m_snz = 0;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
      end else begin
         if (!alarm_en) begin
            model_idle();
         end else begin
            case (m_state)
               0: if (sec_tick && cur_hour == hour_a && cur_min == min_a && cur_sec == 0) begin
                     m_state = 1; m_ring = 0; m_tone = 0; m_buzz = 0;
                  end
               1: begin
                  if (m_stop_en != 0) model_idle();
                  else if (m_snz_en != 0 && m_snz < TB_MAXSNZ) begin
                     m_state = 2; m_snz++; m_timer = TB_SNZMIN * 60; m_buzz = 0;
                  end else begin
                     m_tone++;
                     if (m_tone == TB_TONE) begin m_tone = 0; m_buzz = 1 - m_buzz; end
                     if (sec_tick) begin
                        m_ring++;
                        if (m_ring == TB_RING) model_idle();
                     end
                  end
               end
               default: begin
                  if (m_stop_en != 0) model_idle();
                  else if (sec_tick) begin
                     m_timer--;
                     if (m_timer == 0) begin m_state = 1; m_ring = 0; m_tone = 0; m_buzz = 0; end
                  end
               end
            endcase
         end
         m_stop_en = (stop_btn && m_stop_prev == 0) ? 1 : 0;
         m_snz_en  = (snz_btn && m_snz_prev == 0) ? 1 : 0;
         m_stop_prev = stop_btn ? 1 : 0;
         m_snz_prev  = snz_btn ? 1 : 0;
      end
   endtask

   task automatic run_cycle();
      logic [3:0] exp_v;
      logic [3:0] got;
      model_step();
      exp_q.push_back({2'(m_state), m_buzz[0], m_state != 0});
      @(posedge clk);
      #1;
      got = {state, buzz, alarm_act};
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd1, 32'd0);
      end else begin
         exp_v = exp_q.pop_front();
         check("cycle", 32'(got), 32'(exp_v));
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic set_time(input int h, input int m, input int s);
      cur_hour = 7'(h); cur_min = 7'(m); cur_sec = 7'(s);
   endtask

   task automatic sec_adv();
      if (cur_sec == 59) begin
         cur_sec = 0;
         if (cur_min == 59) begin cur_min = 0; cur_hour = (cur_hour == 23) ? 7'd0 : cur_hour + 7'd1; end
         else cur_min = cur_min + 7'd1;
      end else cur_sec = cur_sec + 7'd1;
      sec_tick = 1'b1;
      run_cycle();
      sec_tick = 1'b0;
      cycles(2);
   endtask

   task automatic sec_many(input int n);
      for (int i = 0; i < n; i++) sec_adv();
   endtask

   task automatic press_snz();
      snz_btn = 1'b1; run_cycle(); snz_btn = 1'b0; cycles(2);
   endtask

   task automatic press_stop();
      stop_btn = 1'b1; run_cycle(); stop_btn = 1'b0; cycles(2);
   endtask

   initial begin
      rst_n = 1'b0; sec_tick = 1'b0; alarm_en = 1'b0; stop_btn = 1'b0; snz_btn = 1'b0;
      hour_a = 7'd7; min_a = 7'd30;
      set_time(7, 29, 58);
      model_reset();
      #2;
      check("reset_state", 32'(state), 32'd0);
      check("reset_buzz", 32'(buzz), 32'd0);
      check("reset_act", 32'(alarm_act), 32'd0);
      cycles(2);
      rst_n = 1'b1;
      alarm_en = 1'b1;
      cycles(2);

      // trigger at 07:30:00, tone toggles every 4 cycles
      sec_adv();
      check("idle_before_match", 32'(state), 32'd0);
      cur_sec = 7'd0; cur_min = 7'd30; sec_tick = 1'b1;
      run_cycle();
      sec_tick = 1'b0;
      check("trigger_state", 32'(state), 32'd1);
      check("trigger_act", 32'(alarm_act), 32'd1);
      cycles(3);
      check("buzz_before_first_toggle", 32'(buzz), 32'd0);
      run_cycle();
      check("buzz_first_toggle", 32'(buzz), 32'd1);
      cycles(4);
      check("buzz_second_toggle", 32'(buzz), 32'd0);

      // auto-off after 5 ticks, no retrigger in the same minute
      sec_many(4);
      check("ring_after_4", 32'(state), 32'd1);
      sec_adv();
      check("auto_off_state", 32'(state), 32'd0);
      check("auto_off_buzz", 32'(buzz), 32'd0);
      sec_many(5);
      check("no_retrigger", 32'(state), 32'd0);

      // snooze twice, third snooze ignored
      set_time(7, 29, 59);
      sec_adv();
      check("trigger2", 32'(state), 32'd1);
      press_snz();
      check("snooze1_state", 32'(state), 32'd2);
      check("snooze1_buzz", 32'(buzz), 32'd0);
      check("snooze1_act", 32'(alarm_act), 32'd1);
      sec_many(59);
      check("snooze1_hold", 32'(state), 32'd2);
      sec_adv();
      check("snooze1_end", 32'(state), 32'd1);
      press_snz();
      check("snooze2_state", 32'(state), 32'd2);
      sec_many(60);
      check("snooze2_end", 32'(state), 32'd1);
      press_snz();
      check("snooze3_ignored", 32'(state), 32'd1);
      press_stop();
      check("stop_state", 32'(state), 32'd0);

      // STOP and SNZ together -> IDLE; snooze count cleared
      set_time(7, 29, 59);
      sec_adv();
      check("trigger3", 32'(state), 32'd1);
      stop_btn = 1'b1; snz_btn = 1'b1;
      run_cycle();
      stop_btn = 1'b0; snz_btn = 1'b0;
      cycles(2);
      check("stop_snz_same", 32'(state), 32'd0);
      set_time(7, 29, 59);
      sec_adv();
      press_snz();
      check("snz_cnt_cleared", 32'(state), 32'd2);

      // disarm during snooze, and disarmed at match time
      alarm_en = 1'b0;
      run_cycle();
      check("disarm_snooze", 32'(state), 32'd0);
      cycles(2);
      set_time(7, 29, 59);
      sec_adv();
      check("disarmed_no_trigger", 32'(state), 32'd0);
      alarm_en = 1'b1;
      sec_many(2);
      check("rearm_no_trigger", 32'(state), 32'd0);

      // out-of-range alarm hour never matches
      hour_a = 7'd24;
      set_time(23, 59, 59);
      sec_adv();
      check("out_of_range", 32'(state), 32'd0);
      hour_a = 7'd7;

      // asynchronous reset mid-ring, SNZ held across release
      set_time(7, 29, 59);
      sec_adv();
      check("trigger4", 32'(state), 32'd1);
      cycles(2);
      #3;
      rst_n = 1'b0;
      snz_btn = 1'b1;
      #1;
      check("async_rst_state", 32'(state), 32'd0);
      check("async_rst_buzz", 32'(buzz), 32'd0);
      check("async_rst_act", 32'(alarm_act), 32'd0);
      model_reset();
      cycles(2);
      rst_n = 1'b1;
      cycles(3);
      check("post_rst_idle", 32'(state), 32'd0);
      set_time(7, 29, 59);
      sec_adv();
      cycles(4);
      check("held_snz_no_snooze", 32'(state), 32'd1);
      snz_btn = 1'b0;
      press_stop();
      check("final_stop", 32'(state), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
